// File: rtl/ir_varlen.sv
// ir_varlen -- variable-length instruction register.
//
// Builds one instruction from an opcode word and 0, 1 or 2 extension words.
// Each word is taken from the shared tri-state data bus on a load strobe.
// The opcode goes to the controller and the assembled operand goes to the
// datapath. The operand can also be driven back onto the bus, one half at a
// time.
//
// Ports:
//   clk        system clock, rising-edge active
//   rst_n      synchronous active-low reset
//   ir_in      load strobe: capture ir_bus on this edge
//   ir_out     drive operand low word onto ir_bus (instruction complete only)
//   ir_out_hi  drive operand high word onto ir_bus (ir_out has priority)
//   ir_clr     synchronous clear back to empty
//   ir_bus     shared DATA_W-bit tri-state data bus
//   ir_ins     opcode of the current instruction
//   ir_add     assembled operand/address, extension words little-endian
//   ir_len     extension word count of the current opcode
//   ir_busy    instruction partially assembled
//   ir_valid   instruction complete
module ir_varlen #(
  parameter int DATA_W    = 8,
  parameter int OP_W      = 4,
  parameter int EXT1_BASE = 8,
  parameter int EXT2_BASE = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ir_in,
  input  logic                ir_out,
  input  logic                ir_out_hi,
  input  logic                ir_clr,
  inout  wire  [DATA_W-1:0]   ir_bus,
  output logic [OP_W-1:0]     ir_ins,
  output logic [2*DATA_W-1:0] ir_add,
  output logic [1:0]          ir_len,
  output logic                ir_busy,
  output logic                ir_valid
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_EXT0  = 2'd1,
    ST_EXT1  = 2'd2,
    ST_FULL  = 2'd3
  } state_t;

  // Number of extension words that follow an opcode.
  function automatic logic [1:0] len_decode(input logic [OP_W-1:0] op);
    logic [1:0] len;
    if (32'(op) < EXT1_BASE) begin
      len = 2'd0;
    end else if (32'(op) < EXT2_BASE) begin
      len = 2'd1;
    end else begin
      len = 2'd2;
    end
    return len;
  endfunction

  state_t              state_r, state_s;
  logic [OP_W-1:0]     ins_r, ins_s;
  logic [2*DATA_W-1:0] add_r, add_s;
  logic [1:0]          len_r, len_s;
  logic                valid_r, busy_r;
  logic                ld_s;

  // A strobe is ignored while this register drives the bus, so it never
  // captures its own output.
  assign ld_s = ir_in & ~ir_out & ~ir_out_hi;

  // Next-state and next-register logic for instruction assembly.
  always_comb begin
    state_s = state_r;
    ins_s   = ins_r;
    add_s   = add_r;
    len_s   = len_r;
    if (ir_clr) begin
      state_s = ST_EMPTY;
      ins_s   = {OP_W{1'b0}};
      add_s   = {(2*DATA_W){1'b0}};
      len_s   = 2'd0;
    end else if (ld_s) begin
      case (state_r)
        // A load in FULL starts the next instruction (back-to-back fetch).
        ST_EMPTY, ST_FULL: begin
          ins_s = ir_bus[DATA_W-1 -: OP_W];
          len_s = len_decode(ir_bus[DATA_W-1 -: OP_W]);
          if (len_s == 2'd0) begin
            add_s   = {{(DATA_W+OP_W){1'b0}}, ir_bus[DATA_W-OP_W-1:0]};
            state_s = ST_FULL;
          end else begin
            add_s   = {(2*DATA_W){1'b0}};
            state_s = ST_EXT0;
          end
        end
        ST_EXT0: begin
          add_s = {{DATA_W{1'b0}}, ir_bus};
          if (len_r == 2'd1) begin
            state_s = ST_FULL;
          end else begin
            state_s = ST_EXT1;
          end
        end
        ST_EXT1: begin
          add_s   = {ir_bus, add_r[DATA_W-1:0]};
          state_s = ST_FULL;
        end
        default: begin
          state_s = ST_EMPTY;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // State and data registers. The status flags are registered from the
  // next state so they match a decode of the state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_EMPTY;
      ins_r   <= {OP_W{1'b0}};
      add_r   <= {(2*DATA_W){1'b0}};
      len_r   <= 2'd0;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      ins_r   <= ins_s;
      add_r   <= add_s;
      len_r   <= len_s;
      valid_r <= (state_s == ST_FULL);
      busy_r  <= (state_s == ST_EXT0) || (state_s == ST_EXT1);
    end
  end

  assign ir_ins   = ins_r;
  assign ir_add   = add_r;
  assign ir_len   = len_r;
  assign ir_valid = valid_r;
  assign ir_busy  = busy_r;

  // Drive the bus only for a complete instruction. The low half wins when
  // both halves are requested.
  assign ir_bus = (valid_r && ir_out)    ? add_r[DATA_W-1:0] :
                  (valid_r && ir_out_hi) ? add_r[2*DATA_W-1:DATA_W] :
                                           {DATA_W{1'bz}};

endmodule
